// File: rtl/exme_skid.sv
// EX->MEM pipeline skid buffer: a main entry that drives the MEM outputs and
// a skid entry that catches one extra EX instruction while MEM is stalled.
module exme_skid #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RDW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            vlde,
    output logic            rdye,
    input  logic            regWrte,
    input  logic            memWrte,
    input  logic [1:0]      rsltSrce,
    input  logic [XLEN-1:0] aluRslte,
    input  logic [XLEN-1:0] wrtDe,
    input  logic [XLEN-1:0] pc4e,
    input  logic [RDW-1:0]  rde,
    output logic            vldm,
    input  logic            rdym,
    output logic            regWrtm,
    output logic            memWrtm,
    output logic [1:0]      rsltSrcm,
    output logic [XLEN-1:0] aluRsltm,
    output logic [XLEN-1:0] wrtDm,
    output logic [XLEN-1:0] pc4m,
    output logic [RDW-1:0]  rdm,
    output logic [1:0]      occ
);

    // Entry layout, MSB first: regWrt, memWrt, rsltSrc, aluRslt, wrtD, pc4, rd
    localparam int unsigned EW      = RDW + 3 * XLEN + 4;
    localparam int unsigned PC4LSB  = RDW;
    localparam int unsigned WDLSB   = RDW + XLEN;
    localparam int unsigned ALULSB  = RDW + 2 * XLEN;
    localparam int unsigned SRCLSB  = RDW + 3 * XLEN;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    stateN;
    logic [EW-1:0] mainQ;
    logic [EW-1:0] mainN;
    logic [EW-1:0] skidQ;
    logic [EW-1:0] skidN;
    logic [EW-1:0] exEnt;
    logic          exXfer;
    logic          memXfer;

    assign exEnt   = {regWrte, memWrte, rsltSrce, aluRslte, wrtDe, pc4e, rde};
    assign exXfer  = vlde & rdye;
    assign memXfer = vldm & rdym;

    // Next-state and next-entry selection; flush overrides any transfer
    always_comb begin
        stateN = state;
        mainN  = mainQ;
        skidN  = skidQ;
        case (state)
            EMPTY: begin
                if (exXfer) begin
                    mainN  = exEnt;
                    stateN = ONE;
                end
            end
            ONE: begin
                if (exXfer && memXfer) begin
                    mainN = exEnt;
                end else if (exXfer) begin
                    skidN  = exEnt;
                    stateN = FULL;
                end else if (memXfer) begin
                    mainN  = '0;
                    stateN = EMPTY;
                end
            end
            FULL: begin
                if (memXfer) begin
                    mainN  = skidQ;
                    skidN  = '0;
                    stateN = ONE;
                end
            end
            default: begin
                mainN  = '0;
                skidN  = '0;
                stateN = EMPTY;
            end
        endcase
        if (flush) begin
            mainN  = '0;
            skidN  = '0;
            stateN = EMPTY;
        end
    end

    // State, entries and status outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
            vldm  <= 1'b0;
            rdye  <= 1'b1;
            occ   <= 2'd0;
        end else begin
            state <= stateN;
            mainQ <= mainN;
            skidQ <= skidN;
            vldm  <= (stateN != EMPTY);
            rdye  <= (stateN != FULL);
            occ   <= stateN;
        end
    end

    // Main entry drives MEM; control bits are zero whenever main is empty
    assign regWrtm  = mainQ[EW-1];
    assign memWrtm  = mainQ[EW-2];
    assign rsltSrcm = mainQ[SRCLSB +: 2];
    assign aluRsltm = mainQ[ALULSB +: XLEN];
    assign wrtDm    = mainQ[WDLSB +: XLEN];
    assign pc4m     = mainQ[PC4LSB +: XLEN];
    assign rdm      = mainQ[RDW-1:0];

endmodule

// File: tb/tb_exme_skid.sv
// Self-checking bench for exme_skid: directed scenarios plus a random run,
// with a queue holding the instructions the block should currently hold.
module tb_exme_skid;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RDW  = 5;
    localparam int unsigned EW   = RDW + 3 * XLEN + 4;

    logic            clk;
    logic            rstn;
    logic            flush;
    logic            vlde;
    logic            rdye;
    logic            regWrte;
    logic            memWrte;
    logic [1:0]      rsltSrce;
    logic [XLEN-1:0] aluRslte;
    logic [XLEN-1:0] wrtDe;
    logic [XLEN-1:0] pc4e;
    logic [RDW-1:0]  rde;
    logic            vldm;
    logic            rdym;
    logic            regWrtm;
    logic            memWrtm;
    logic [1:0]      rsltSrcm;
    logic [XLEN-1:0] aluRsltm;
    logic [XLEN-1:0] wrtDm;
    logic [XLEN-1:0] pc4m;
    logic [RDW-1:0]  rdm;
    logic [1:0]      occ;

    logic [EW-1:0] sbQ[$];
    int unsigned   passCnt;
    int unsigned   totalCnt;
    int unsigned   retired;

    exme_skid #(.XLEN(XLEN), .RDW(RDW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .vlde(vlde), .rdye(rdye),
        .regWrte(regWrte), .memWrte(memWrte), .rsltSrce(rsltSrce),
        .aluRslte(aluRslte), .wrtDe(wrtDe), .pc4e(pc4e), .rde(rde),
        .vldm(vldm), .rdym(rdym), .regWrtm(regWrtm), .memWrtm(memWrtm),
        .rsltSrcm(rsltSrcm), .aluRsltm(aluRsltm), .wrtDm(wrtDm),
        .pc4m(pc4m), .rdm(rdm), .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: update the model from the handshakes, then check status
    task automatic step();
        int unsigned depth;
        bit          ex;
        bit          mem;
        depth = sbQ.size();
        ex    = vlde && (depth < 2);
        mem   = rdym && (depth > 0);
        if (!rstn || flush) begin
            sbQ.delete();
        end else begin
            if (mem) begin
                void'(sbQ.pop_front());
                retired++;
            end
            if (ex) sbQ.push_back({regWrte, memWrte, rsltSrce, aluRslte, wrtDe, pc4e, rde});
        end
        @(posedge clk);
        #1;
        chk("occ", 128'(occ), 128'(sbQ.size()));
        chk("vldm", 128'(vldm), 128'(sbQ.size() > 0));
        chk("rdye", 128'(rdye), 128'(sbQ.size() < 2));
        if (sbQ.size() > 0)
            chk("head", 128'({regWrtm, memWrtm, rsltSrcm, aluRsltm, wrtDm, pc4m, rdm}),
                128'(sbQ[0]));
        else
            chk("ctrlIdle", 128'({regWrtm, memWrtm}), 128'(2'b00));
    endtask

    task automatic randEx();
        regWrte  = 1'($urandom);
        memWrte  = 1'($urandom);
        rsltSrce = 2'($urandom);
        aluRslte = $urandom;
        wrtDe    = $urandom;
        pc4e     = $urandom;
        rde      = RDW'($urandom);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        retired  = 0;
        rstn     = 1'b0;
        flush    = 1'b0;
        vlde     = 1'b0;
        rdym     = 1'b0;
        randEx();

        // Reset state
        step();
        chk("rstAlu", 128'(aluRsltm), 128'(0));
        chk("rstPc4", 128'(pc4m), 128'(0));
        rstn = 1'b1;

        // Streaming at one instruction per cycle
        vlde = 1'b1; rdym = 1'b1; aluRslte = 32'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("streamAlu", 128'(aluRsltm), 128'(32'h10));
        end
        chk("streamRetired", 128'(retired), 128'(4));

        // Fill to FULL, third push refused, drain in order
        vlde = 1'b0; step();
        rdym = 1'b0; vlde = 1'b1;
        pc4e = 32'h4; step();
        pc4e = 32'h8; step();
        pc4e = 32'hC; step();
        chk("fullRdye", 128'(rdye), 128'(0));
        chk("fullHead", 128'(pc4m), 128'(32'h4));
        vlde = 1'b0; rdym = 1'b1;
        step();
        chk("drain2", 128'(pc4m), 128'(32'h8));
        step();
        chk("drainOcc", 128'(occ), 128'(0));

        // Flush in FULL drops everything including the EX instruction
        rdym = 1'b0; vlde = 1'b1; randEx(); regWrte = 1'b1; memWrte = 1'b1;
        step(); randEx(); regWrte = 1'b1; step();
        flush = 1'b1; randEx(); step();
        flush = 1'b0; vlde = 1'b0;
        chk("flushOcc", 128'(occ), 128'(0));
        step();
        chk("flushStay", 128'(vldm), 128'(0));

        // ONE with simultaneous EX and MEM transfer replaces main
        vlde = 1'b1; rdym = 1'b0; randEx(); memWrte = 1'b1; step();
        rdym = 1'b1; randEx(); memWrte = 1'b0; rde = 5'd7; step();
        chk("replRd", 128'(rdm), 128'(7));
        chk("replMw", 128'(memWrtm), 128'(0));
        chk("replOcc", 128'(occ), 128'(1));
        vlde = 1'b0; step();

        // Reset in FULL beats flush and MEM handshake
        vlde = 1'b1; rdym = 1'b0; randEx(); step(); randEx(); step();
        rstn = 1'b0; flush = 1'b1; rdym = 1'b1; vlde = 1'b0; step();
        chk("rstFullAlu", 128'(aluRsltm), 128'(0));
        chk("rstFullPc4", 128'(pc4m), 128'(0));
        rstn = 1'b1; flush = 1'b0;

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            vlde  = ($urandom_range(0, 3) != 0);
            rdym  = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            randEx();
            step();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/exme_skid.md
EXME_SKID -- requirements
Module: exme_skid

Interface
REQ-001 Parameter XLEN, default 32: width of the ALU result, store data and PC+4 fields.
REQ-002 Parameter RDW, default 5: width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-005 flush  input  1  kills every instruction held in the block.
REQ-006 vlde  input  1  EX side has a valid instruction.
REQ-007 rdye  output  1  block can accept an EX instruction this cycle.
REQ-008 regWrte, memWrte  input  1 each  EX control bits.
REQ-009 rsltSrce  input  2  EX result-select.
REQ-010 aluRslte, wrtDe, pc4e  input  XLEN each  EX datapath values.
REQ-011 rde  input  RDW  EX destination register index.
REQ-012 vldm  output  1  MEM side holds a valid instruction.
REQ-013 rdym  input  1  MEM side accepts the instruction this cycle.
REQ-014 regWrtm, memWrtm, rsltSrcm, aluRsltm, wrtDm, pc4m, rdm  output  widths as EX counterparts  MEM-side copies.
REQ-015 occ  output  2  number of held entries (0, 1 or 2).

Function
REQ-016 Two-entry skid buffer: a main entry (drives MEM outputs) and a skid entry; each entry stores all EX fields plus a valid bit.
REQ-017 States: EMPTY (occ=0), ONE (main valid, skid empty, occ=1), FULL (both valid, occ=2); occ never exceeds 2.
REQ-018 rdye is 1 in EMPTY and ONE and 0 in FULL; rdye is a register output and does not depend combinationally on rdym.
REQ-019 An EX transfer occurs when vlde=1 and rdye=1; a MEM transfer occurs when vldm=1 and rdym=1.
REQ-020 vldm equals the main-entry valid bit; MEM outputs reflect the main entry's fields.
REQ-021 EMPTY: an EX transfer loads main and moves to ONE; latency from EX transfer to vldm=1 is exactly one cycle.
REQ-022 ONE, EX and MEM transfers together: main is reloaded from EX; the state stays ONE.
REQ-023 ONE, EX transfer only: the EX instruction goes to skid; the state moves to FULL.
REQ-024 ONE, MEM transfer only: the state moves to EMPTY.
REQ-025 FULL, MEM transfer: skid moves to main, skid is cleared, and the state moves to ONE; no EX transfer is possible in FULL.
REQ-026 In all other cases the state and stored fields hold unchanged.
REQ-027 Order is preserved: MEM sees instructions in EX-acceptance order with no loss or duplication.
REQ-028 regWrtm and memWrtm are forced to 0 whenever vldm=0; other MEM fields are don't-care when vldm=0.
REQ-029 flush=1 (with rstn=1) clears both valid bits and moves to EMPTY at the next edge.
REQ-030 flush has priority over a simultaneous EX or MEM transfer: the EX instruction is dropped, although rdye may be 1 that cycle.
REQ-031 The bench treats a MEM handshake that coincides with flush as completed; the block takes no further action for it.
REQ-032 No arithmetic on data fields; all fields are stored bit-exact.

Reset
REQ-033 rstn=0 at a rising edge puts the block in EMPTY: valid bits 0, occ=0, rdye=1, vldm=0, and all stored fields zeroed.
REQ-034 Reset has priority over flush and over both transfers; reset in FULL discards both entries.
REQ-035 Outputs between power-up and the first reset edge are undefined.

Verification
REQ-036 Reset, then vlde=1 with aluRslte=0x00000010 and rdym=1 every cycle: vldm=1 and aluRsltm=0x10 one cycle later; occ stays 1; one instruction retires per cycle.
REQ-037 rdym=0; push A (pc4e=0x4) then B (pc4e=0x8): occ=2 and rdye=0; a third vlde is not accepted; then rdym=1 for 2 cycles: MEM sees 0x4 then 0x8; occ returns to 0.
REQ-038 FULL state, flush=1 with vlde=1: next cycle occ=0, vldm=0, regWrtm=0, memWrtm=0, rdye=1; the EX instruction is not observed on MEM.
REQ-039 ONE state holding memWrte=1, then vlde=1 and rdym=1 in the same cycle with memWrte=0, rde=7: main is replaced, rdm=7, memWrtm=0, occ=1.
REQ-040 FULL state, rstn=0 for one edge while flush=1 and rdym=1: occ=0, vldm=0, aluRsltm=0, pc4m=0.
REQ-041 Random vlde/rdym/flush for 10k cycles against a scoreboard queue: order is preserved, no loss except on flush, and occ matches the queue depth.
